ni_traffic_injector: RTL
========================

// Module: ni_traffic_injector
// PURPOSE
//  Per-core synthetic network interface sitting on the NI side of the NoC interconnect.
//  Injects a programmed number of fixed-length wormhole packets into the router local port.
//  Tracks per-VC credits; sinks ejected flits and returns their credits.
//  Counts sent/received packets for the simulation top; launched by its per-core start pulse.
// PARAMETERS
//  V       2   virtual channels per port
//  B       4   buffer depth (flits) per VC at router input = initial credit per VC
//  Fpay    32  flit payload width; Fw = 2+V+Fpay
//  PCK_LEN 4   flits per packet, >=2 (head + bodies + tail)
//  DSTw    6   destination address field width, DSTw <= Fpay-16
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      one-cycle launch pulse
//  dest_addr    in   DSTw   destination core, sampled on accepted start
//  pck_number   in   16     packets to send, sampled on accepted start
//  flit_out     out  Fw     flit to router local input
//  flit_out_wr  out  1      flit_out valid
//  credit_in    in   V      one credit returned per asserted bit (router -> NI)
//  flit_in      in   Fw     flit ejected from router local output
//  flit_in_wr   in   1      flit_in valid
//  credit_out   out  V      credit returned to router, one bit per VC
//  done         out  1      all packets sent, level until reset
//  sent_pck_cnt out  16     tail flits sent
//  recv_pck_cnt out  16     tail flits received
// BEHAVIOUR
//  Flit format: [Fw-1]=head, [Fw-2]=tail, [Fpay+V-1:Fpay]=VC one-hot, [Fpay-1:0]=payload.
//    Head payload = {16'(packet seq #), zero pad, dest_addr}; body/tail payload = flit index 1..PCK_LEN-1.
//  Reset: all outputs 0; FSM=IDLE; every credit counter = B; seq = 0.
//  FSM IDLE:
//    start=1, pck_number>0: latch dest_addr/pck_number, go to SEND.
//    start=1, pck_number=0: go to DONE.
//  FSM SEND:
//    At packet start, pick VC round-robin (from last used VC + 1) among VCs with credit>0.
//    The VC is held for the whole packet; no interleaving of packets.
//    Each cycle, issue the next flit if the held VC credit>0, else stall (flit_out_wr=0).
//  Outputs flit_out/flit_out_wr are registered: the flit appears the cycle after the issue decision.
//    flit_out_wr is high for exactly one cycle per flit.
//  Tail issue: sent_pck_cnt+1 and seq+1. The last tail of pck_number moves to DONE.
//  FSM DONE: done=1; stays until reset; start ignored. Start in SEND is also ignored.
//  Credit counter per VC (width log2(B+1)): -1 on issue on that VC; +1 on credit_in[v].
//    Both in the same cycle -> unchanged.
//    Overflow above B or underflow below 0 is an error; the bench asserts it never occurs.
//  Receive side (always ready): on flit_in_wr, credit_out = flit_in VC field, registered, 1 cycle later.
//    credit_out = 0 otherwise.
//    Tail received -> recv_pck_cnt+1; 16-bit wrap at 0xFFFF -> 0.
//  Receive path is independent of FSM state; it counts in IDLE and DONE too.
//  A reset mid-packet discards the packet: counters return to reset values and no tail is sent.
// TESTING
//  1. Reset, then start with pck_number=1, dest=5, PCK_LEN=4, credits returned 2 cycles after each flit.
//     -> 4 flits on VC0: head payload low bits 5, tail bit only on 4th; sent=1; done=1.
//  2. pck_number=3, no credit_in ever, B=4.
//     -> pkt0 on VC0 (4 flits), pkt1 on VC1 (4 flits), then stall.
//     -> flit_out_wr=0 forever, sent=2, done=0.
//  3. Same as 2, then pulse credit_in=2'b01 once.
//     -> exactly one flit (head of pkt2, VC0) issued next cycle, then stall.
//  4. Issue a flit and assert credit_in on the same VC in the same cycle.
//     -> that VC counter unchanged; no overflow assertion.
//  5. Drive flit_in_wr with VC field 2'b10 and tail=1 for 3 cycles.
//     -> credit_out=2'b10 on the 3 following cycles; recv_pck_cnt=3.
//  6. start with pck_number=0 -> done=1 next cycle, no flits.
//     Reset asserted mid-packet -> all outputs 0, credits=B, restart works.

Source files
------------

// File: rtl/ni_traffic_injector.sv
// Synthetic NI: injects pck_number fixed-length wormhole packets, sinks ejected flits.
// Latency: flit appears one cycle after its issue decision; credit_out one cycle after flit_in_wr.
// Backpressure: stalls issue while the held VC has no credit; receive side is always ready.
module ni_traffic_injector #(
  parameter int V       = 2,
  parameter int B       = 4,
  parameter int FPAY    = 32,
  parameter int PCK_LEN = 4,
  parameter int DSTW    = 6,
  localparam int FW     = 2 + V + FPAY
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [DSTW-1:0] dest_addr,
  input  logic [15:0]     pck_number,
  output logic [FW-1:0]   flit_out,
  output logic            flit_out_wr,
  input  logic [V-1:0]    credit_in,
  input  logic [FW-1:0]   flit_in,
  input  logic            flit_in_wr,
  output logic [V-1:0]    credit_out,
  output logic            done,
  output logic [15:0]     sent_pck_cnt,
  output logic [15:0]     recv_pck_cnt
);

  localparam int CW   = $clog2(B + 1);
  localparam int VCW  = (V > 1) ? $clog2(V) : 1;
  localparam int IDXW = $clog2(PCK_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  state_t            state, next_state;
  logic [DSTW-1:0]   dest_r;
  logic [15:0]       pck_left;
  logic [15:0]       seq;
  logic [IDXW-1:0]   flit_idx;
  logic [VCW-1:0]    cur_vc;
  logic [VCW-1:0]    last_vc;
  logic [CW-1:0]     credit_cnt [V];

  logic              issue;
  logic              found;
  logic [VCW-1:0]    pick;
  logic [VCW-1:0]    cand_idx;
  logic [VCW-1:0]    vc_sel;
  logic              is_head;
  logic              is_tail;
  logic [V-1:0]      cred_dec;
  logic [V-1:0]      vc_onehot;
  logic [FPAY-1:0]   payload;
  logic [FW-1:0]     flit_nxt;

  assign is_head = (flit_idx == '0);
  assign is_tail = (flit_idx == IDXW'(PCK_LEN - 1));
  assign done    = (state == ST_DONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Round-robin VC pick, issue decision and next state
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    vc_sel     = cur_vc;
    found      = 1'b0;
    pick       = '0;
    cand_idx   = '0;
    for (int i = 0; i < V; i++) begin
      cand_idx = VCW'((int'(last_vc) + 1 + i) % V);
      if (!found && credit_cnt[cand_idx] != '0) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
    case (state)
      ST_IDLE: begin
        if (start) next_state = (pck_number == 16'd0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (is_head) begin
          issue  = found;
          vc_sel = pick;
        end else begin
          issue  = (credit_cnt[cur_vc] != '0);
        end
        if (issue && is_tail && pck_left == 16'd1) next_state = ST_DONE;
      end
      default: next_state = state;
    endcase
  end

  // Flit assembly for the current issue decision
  always_comb begin
    vc_onehot = {{(V-1){1'b0}}, 1'b1} << vc_sel;
    if (is_head) payload = {seq, {(FPAY-16-DSTW){1'b0}}, dest_r};
    else         payload = FPAY'(flit_idx);
    flit_nxt  = {is_head, is_tail, vc_onehot, payload};
    cred_dec  = issue ? vc_onehot : '0;
  end

  // Injection datapath: output register, packet bookkeeping, latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out     <= '0;
      flit_out_wr  <= 1'b0;
      dest_r       <= '0;
      pck_left     <= '0;
      seq          <= '0;
      flit_idx     <= '0;
      cur_vc       <= '0;
      last_vc      <= VCW'(V - 1);
      sent_pck_cnt <= '0;
    end else begin
      flit_out_wr <= issue;
      flit_out    <= issue ? flit_nxt : '0;
      if (state == ST_IDLE && start && pck_number != 16'd0) begin
        dest_r   <= dest_addr;
        pck_left <= pck_number;
      end
      if (issue) begin
        if (is_head) begin
          cur_vc  <= vc_sel;
          last_vc <= vc_sel;
        end
        if (is_tail) begin
          flit_idx     <= '0;
          sent_pck_cnt <= sent_pck_cnt + 16'd1;
          seq          <= seq + 16'd1;
          pck_left     <= pck_left - 16'd1;
        end else begin
          flit_idx <= flit_idx + 1'b1;
        end
      end
    end
  end

  // Per-VC credit counters; simultaneous issue and return cancel out
  always_ff @(posedge clk) begin
    for (int v = 0; v < V; v++) begin
      if (reset)                          credit_cnt[v] <= CW'(B);
      else if (cred_dec[v] && !credit_in[v]) credit_cnt[v] <= credit_cnt[v] - 1'b1;
      else if (!cred_dec[v] && credit_in[v]) credit_cnt[v] <= credit_cnt[v] + 1'b1;
    end
  end

  // Receive sink: echo the flit VC as a credit, count tails
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_out   <= '0;
      recv_pck_cnt <= '0;
    end else begin
      credit_out <= flit_in_wr ? flit_in[FPAY +: V] : '0;
      if (flit_in_wr && flit_in[FW-2]) recv_pck_cnt <= recv_pck_cnt + 16'd1;
    end
  end

endmodule
